mem_arbiter: RTL and testbench

- Shares the single cache/main-memory port between the instruction-fetch stage and the load/store stage.
- Registers a grant, drives the memory-side request from the winning requester, and passes back read data.
- Returns a one-cycle acknowledge to the winner when the memory-side ready arrives.
- Sits between the pipeline front/back ends and the memory top (cache + main memory + extend unit).

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single cache/main-memory port between the instruction-fetch
//   stage and the load/store stage. A grant is registered, the winner's request
//   is steered onto the memory side, and a one-cycle acknowledge (with read
//   data) is returned to the winner when the memory signals ready.
//
//   Optional feature (macro MEM_ARB_RR_EN):
//     defined   - on a conflict the grant alternates away from the last winner
//     undefined - fixed data-over-fetch priority
//
//   Ports:
//     clk, rst            clock (rising edge), asynchronous active-high reset
//     ireq_i, iaddr_i     fetch request / address
//     irdata_o, iack_o    fetch data (valid with iack_o) / completion pulse
//     dread_i, dwrite_i   load / store request
//     daddr_i, dwdata_i   data address / store data
//     dfunct3_i           load/store width code
//     drdata_o, dack_o    load data (valid with dack_o) / completion pulse
//     mem_*_o             memory-side address, write data, enables, width code
//     mem_rdata_i         memory read data
//     mem_ready_i         memory transaction complete
//     busy_o              a grant is active
//     conflict_cnt_o      saturating count of conflicting arbitration cycles
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ireq_i,
    input  logic [AW-1:0]    iaddr_i,
    output logic [DW-1:0]    irdata_o,
    output logic             iack_o,
    input  logic             dread_i,
    input  logic             dwrite_i,
    input  logic [AW-1:0]    daddr_i,
    input  logic [DW-1:0]    dwdata_i,
    input  logic [2:0]       dfunct3_i,
    output logic [DW-1:0]    drdata_o,
    output logic             dack_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [DW-1:0]    mem_wdata_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [2:0]       mem_funct3_o,
    input  logic [DW-1:0]    mem_rdata_i,
    input  logic             mem_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    state_t           state_q, state_d;
    src_t             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic d_pend_s;
    logic both_pend_s;

    assign d_pend_s       = dread_i | dwrite_i;
    assign both_pend_s    = ireq_i & d_pend_s;
    assign conflict_cnt_o = conflict_cnt_q;

    // State, last winner and conflict counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= SRC_D;
            conflict_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Next-state logic and memory-side / requester-side outputs
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        conflict_cnt_d = conflict_cnt_q;
        irdata_o       = {DW{1'b0}};
        iack_o         = 1'b0;
        drdata_o       = {DW{1'b0}};
        dack_o         = 1'b0;
        mem_addr_o     = {AW{1'b0}};
        mem_wdata_o    = {DW{1'b0}};
        mem_read_o     = 1'b0;
        mem_write_o    = 1'b0;
        mem_funct3_o   = 3'b000;
        busy_o         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // mem_ready_i is deliberately ignored here
                if (both_pend_s) begin
                    if (conflict_cnt_q != {CNT_W{1'b1}}) begin
                        conflict_cnt_d = conflict_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        conflict_cnt_d = conflict_cnt_q;
                    end
`ifdef MEM_ARB_RR_EN
                    // Alternate away from whoever completed last
                    if (last_grant_q == SRC_D) begin
                        state_d = ST_GNT_I;
                    end else begin
                        state_d = ST_GNT_D;
                    end
`else
                    state_d = ST_GNT_D;
`endif
                end else if (d_pend_s) begin
                    state_d = ST_GNT_D;
                end else if (ireq_i) begin
                    state_d = ST_GNT_I;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GNT_I: begin
                busy_o       = 1'b1;
                mem_read_o   = 1'b1;
                mem_addr_o   = iaddr_i;
                mem_funct3_o = 3'b010;
                // A withdrawn request releases the port silently so the
                // arbiter can never hang on a misbehaving requester.
                if (!ireq_i) begin
                    state_d = ST_IDLE;
                end else if (mem_ready_i) begin
                    iack_o       = 1'b1;
                    irdata_o     = mem_rdata_i;
                    state_d      = ST_IDLE;
                    last_grant_d = SRC_I;
                end else begin
                    state_d = ST_GNT_I;
                end
            end

            ST_GNT_D: begin
                busy_o       = 1'b1;
                mem_write_o  = dwrite_i;
                mem_read_o   = dread_i & ~dwrite_i;
                mem_addr_o   = daddr_i;
                mem_wdata_o  = dwdata_i;
                mem_funct3_o = dfunct3_i;
                if (!d_pend_s) begin
                    state_d = ST_IDLE;
                end else if (mem_ready_i) begin
                    dack_o       = 1'b1;
                    drdata_o     = mem_rdata_i;
                    state_d      = ST_IDLE;
                    last_grant_d = SRC_D;
                end else begin
                    state_d = ST_GNT_D;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CNT_W = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ireq, dread, dwrite, mem_ready;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dwdata, mem_rdata;
    logic [2:0]    dfunct3;

    logic [DW-1:0] irdata, drdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic iack, dack, mem_read, mem_write, busy;
    logic [2:0] mem_funct3;
    logic [CNT_W-1:0] conflict_cnt;

    logic [DW-1:0] s_irdata, s_drdata, s_mem_wdata;
    logic [AW-1:0] s_mem_addr;
    logic s_iack, s_dack, s_mem_read, s_mem_write, s_busy;
    logic [2:0] s_mem_funct3;
    logic [3:0] s_conflict_cnt;

    logic [135:0] all_nc;
    assign all_nc = {irdata, iack, drdata, dack, mem_addr, mem_wdata,
                     mem_read, mem_write, mem_funct3, busy};

    int total = 0;
    int bad   = 0;
    int exp_cnt  = 0;
    int exp_last = 2;   // 1 = fetch, 2 = data

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .ireq_i(ireq), .iaddr_i(iaddr), .irdata_o(irdata), .iack_o(iack),
        .dread_i(dread), .dwrite_i(dwrite), .daddr_i(daddr), .dwdata_i(dwdata),
        .dfunct3_i(dfunct3), .drdata_o(drdata), .dack_o(dack),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .mem_funct3_o(mem_funct3),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .busy_o(busy), .conflict_cnt_o(conflict_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    mem_arbiter #(.AW(AW), .DW(DW), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .ireq_i(ireq), .iaddr_i(iaddr), .irdata_o(s_irdata), .iack_o(s_iack),
        .dread_i(dread), .dwrite_i(dwrite), .daddr_i(daddr), .dwdata_i(dwdata),
        .dfunct3_i(dfunct3), .drdata_o(s_drdata), .dack_o(s_dack),
        .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata), .mem_read_o(s_mem_read),
        .mem_write_o(s_mem_write), .mem_funct3_o(s_mem_funct3),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .busy_o(s_busy), .conflict_cnt_o(s_conflict_cnt)
    );

    // Winner of a conflict given the last requester that completed
    function automatic int winner(input int last);
        return (RR_EN && last == 2) ? 1 : 2;
    endfunction

    function automatic logic [3:0] sat4(input int n);
        logic [3:0] r;
        r = (n > 15) ? 4'hF : n[3:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireq = 1'b0; dread = 1'b0; dwrite = 1'b0; mem_ready = 1'b0;
        iaddr = '0; daddr = '0; dwdata = '0; dfunct3 = 3'b000; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        ireq = 1'b1; dread = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (all_nc !== 136'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", all_nc);
        end
        total++;
        if ({conflict_cnt, s_conflict_cnt} !== 20'd0) begin
            bad++; $display("FAIL reset_cnt: got %h/%h want 0", conflict_cnt, s_conflict_cnt);
        end
        clear_inputs();
        tick();
        rst = 1'b0;
        exp_cnt = 0; exp_last = 2;
    endtask

    task automatic test_fetch_only();
        tick();
        ireq = 1'b1; iaddr = 32'h0000_0100; mem_rdata = 32'h0010_0093; mem_ready = 1'b0;
        #1;
        total++;
        if ({busy, mem_read} !== 2'b00) begin
            bad++; $display("FAIL fetch_idle: got busy/read %b want 00", {busy, mem_read});
        end
        tick(); #1;
        total++;
        if ({mem_read, mem_write, mem_funct3, mem_addr, mem_wdata, busy, iack, dack} !==
            {1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL fetch_grant: got rd=%b wr=%b f3=%b a=%h wd=%h busy=%b ack=%b%b want 1 0 010 100 0 1 00",
                            mem_read, mem_write, mem_funct3, mem_addr, mem_wdata, busy, iack, dack);
        end
        repeat (2) begin
            tick(); #1;
            total++;
            if ({iack, dack, mem_read} !== 3'b001) begin
                bad++; $display("FAIL fetch_wait: got ack=%b%b rd=%b want 00 1", iack, dack, mem_read);
            end
        end
        tick(); mem_ready = 1'b1; #1;
        total++;
        if ({iack, irdata, dack} !== {1'b1, 32'h0010_0093, 1'b0}) begin
            bad++; $display("FAIL fetch_ack: got iack=%b irdata=%h dack=%b want 1 00100093 0", iack, irdata, dack);
        end
        tick(); ireq = 1'b0; mem_ready = 1'b0; #1;
        total++;
        if ({iack, busy, irdata} !== 34'd0) begin
            bad++; $display("FAIL fetch_after: got iack=%b busy=%b irdata=%h want 0 0 0", iack, busy, irdata);
        end
        exp_last = 1;
    endtask

    task automatic test_store();
        tick();
        dwrite = 1'b1; daddr = 32'h0000_0040; dwdata = 32'hDEAD_BEEF; dfunct3 = 3'b000;
        mem_rdata = 32'h1234_5678; mem_ready = 1'b0;
        tick(); #1;
        total++;
        if ({mem_write, mem_read, mem_wdata, mem_funct3, mem_addr, dack} !==
            {1'b1, 1'b0, 32'hDEAD_BEEF, 3'b000, 32'h0000_0040, 1'b0}) begin
            bad++; $display("FAIL store_grant: got wr=%b rd=%b wd=%h f3=%b a=%h dack=%b want 1 0 deadbeef 000 40 0",
                            mem_write, mem_read, mem_wdata, mem_funct3, mem_addr, dack);
        end
        tick(); mem_ready = 1'b1; #1;
        total++;
        if ({dack, iack, mem_read, drdata} !== {1'b1, 1'b0, 1'b0, 32'h1234_5678}) begin
            bad++; $display("FAIL store_ack: got dack=%b iack=%b rd=%b drdata=%h want 1 0 0 12345678",
                            dack, iack, mem_read, drdata);
        end
        tick(); dwrite = 1'b0; mem_ready = 1'b0; #1;
        total++;
        if ({dack, busy, mem_write} !== 3'b000) begin
            bad++; $display("FAIL store_after: got dack=%b busy=%b wr=%b want 000", dack, busy, mem_write);
        end
        exp_last = 2;
    endtask

    task automatic test_conflict();
        int w;
        int l;
        w = winner(exp_last);
        l = 3 - w;
        tick();
        ireq = 1'b1; iaddr = 32'h0000_0200; dread = 1'b1; daddr = 32'h0000_0300;
        dfunct3 = 3'b100; mem_ready = 1'b0; mem_rdata = 32'hA5A5_0001;
        tick(); #1;
        exp_cnt++;
        total++;
        if ({busy, mem_read, mem_addr, conflict_cnt} !==
            {1'b1, 1'b1, (w == 2) ? 32'h0000_0300 : 32'h0000_0200, exp_cnt[15:0]}) begin
            bad++; $display("FAIL conflict_first: got busy=%b rd=%b a=%h cnt=%0d want winner %0d cnt=%0d",
                            busy, mem_read, mem_addr, conflict_cnt, w, exp_cnt);
        end
        mem_ready = 1'b1; #1;
        total++;
        if ({iack, dack, (w == 1) ? irdata : drdata} !== {(w == 1), (w == 2), 32'hA5A5_0001}) begin
            bad++; $display("FAIL conflict_first_ack: got iack=%b dack=%b want winner %0d", iack, dack, w);
        end
        tick();
        if (w == 2) dread = 1'b0; else ireq = 1'b0;
        mem_ready = 1'b0; #1;
        total++;
        if ({busy, iack, dack} !== 3'b000) begin
            bad++; $display("FAIL conflict_bubble: got busy=%b acks=%b%b want 000", busy, iack, dack);
        end
        tick(); mem_ready = 1'b1; mem_rdata = 32'hA5A5_0002; #1;
        total++;
        if ({iack, dack, mem_addr} !== {(l == 1), (l == 2), (l == 2) ? 32'h0000_0300 : 32'h0000_0200}) begin
            bad++; $display("FAIL conflict_second: got acks=%b%b a=%h want loser %0d", iack, dack, mem_addr, l);
        end
        exp_last = l;
        tick(); ireq = 1'b0; dread = 1'b0; mem_ready = 1'b0; #1;
        total++;
        if ({busy, conflict_cnt} !== {1'b0, exp_cnt[15:0]}) begin
            bad++; $display("FAIL conflict_cnt: got busy=%b cnt=%0d want 0 %0d", busy, conflict_cnt, exp_cnt);
        end
    endtask

    // Illegal use: the granted fetch withdraws; the arbiter must fall back to IDLE
    task automatic test_withdraw();
        tick(); ireq = 1'b1; iaddr = 32'h0000_0400; mem_ready = 1'b0;
        tick(); #1;
        total++;
        if ({busy, mem_read} !== 2'b11) begin
            bad++; $display("FAIL withdraw_grant: got busy/read %b want 11", {busy, mem_read});
        end
        tick(); ireq = 1'b0;
        $display("note: fetch request withdrawn before ready (requester contract violation)");
        #1;
        total++;
        if ({iack, dack} !== 2'b00) begin
            bad++; $display("FAIL withdraw_noack: got acks %b%b want 00", iack, dack);
        end
        tick(); #1;
        total++;
        if ({busy, iack} !== 2'b00) begin
            bad++; $display("FAIL withdraw_idle: got busy=%b iack=%b want 0 0", busy, iack);
        end
    endtask

    task automatic test_reset_mid();
        tick(); dread = 1'b1; daddr = 32'h0000_0500; dfunct3 = 3'b010; mem_ready = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
        tick(); #1;
        total++;
        if ({busy, mem_read} !== 2'b11) begin
            bad++; $display("FAIL rstmid_grant: got busy/read %b want 11", {busy, mem_read});
        end
        #2; rst = 1'b1; #1;
        exp_cnt = 0; exp_last = 2;
        total++;
        if ({all_nc, conflict_cnt, s_conflict_cnt} !== 156'd0) begin
            bad++; $display("FAIL rstmid_async: got %h cnt=%0d want 0", all_nc, conflict_cnt);
        end
        @(posedge clk); #2;
        total++;
        if ({all_nc, conflict_cnt} !== 152'd0) begin
            bad++; $display("FAIL rstmid_held: got %h want 0", all_nc);
        end
        rst = 1'b0;
        tick(); #1;
        total++;
        if ({busy, mem_read, mem_addr, dack} !== {1'b1, 1'b1, 32'h0000_0500, 1'b0}) begin
            bad++; $display("FAIL rstmid_regrant: got busy=%b rd=%b a=%h dack=%b want 1 1 500 0",
                            busy, mem_read, mem_addr, dack);
        end
        mem_ready = 1'b1; #1;
        total++;
        if ({dack, drdata} !== {1'b1, 32'h0BAD_F00D}) begin
            bad++; $display("FAIL rstmid_ack: got dack=%b drdata=%h want 1 0badf00d", dack, drdata);
        end
        tick(); dread = 1'b0; mem_ready = 1'b0; #1;
        exp_last = 2;
    endtask

    task automatic test_saturation();
        int w;
        int l;
        tick();
        ireq = 1'b1; iaddr = 32'h0000_0600; dread = 1'b1; daddr = 32'h0000_0700;
        dfunct3 = 3'b010; mem_ready = 1'b0; mem_rdata = 32'h0000_0077;
        for (int k = 0; k < 20; k++) begin
            w = winner(exp_last);
            tick(); mem_ready = 1'b1; #1;
            exp_cnt++;
            total++;
            if ({iack, dack, conflict_cnt, s_conflict_cnt} !==
                {(w == 1), (w == 2), exp_cnt[15:0], sat4(exp_cnt)}) begin
                bad++; $display("FAIL sat_step%0d: got acks=%b%b cnt=%0d sat=%h want winner %0d cnt=%0d sat=%h",
                                k, iack, dack, conflict_cnt, s_conflict_cnt, w, exp_cnt, sat4(exp_cnt));
            end
            exp_last = w;
            tick(); mem_ready = 1'b0; #1;
        end
        // Let the other requester finish without a further conflict
        if (exp_last == 2) dread = 1'b0; else ireq = 1'b0;
        l = 3 - exp_last;
        tick(); mem_ready = 1'b1; #1;
        total++;
        if ({iack, dack} !== {(l == 1), (l == 2)}) begin
            bad++; $display("FAIL sat_drain: got acks=%b%b want requester %0d", iack, dack, l);
        end
        exp_last = l;
        tick(); ireq = 1'b0; dread = 1'b0; mem_ready = 1'b0; #1;
        total++;
        if ({s_conflict_cnt, conflict_cnt} !== {4'hF, exp_cnt[15:0]}) begin
            bad++; $display("FAIL sat_hold: got sat=%h cnt=%0d want f %0d", s_conflict_cnt, conflict_cnt, exp_cnt);
        end
    endtask

    // Random legal requesters and memory, checked against a transaction model
    task automatic test_random(input int ncyc);
        int owner;          // 0 none, 1 fetch holds the port, 2 data holds the port
        bit i_pend, d_pend, i_done, d_done, d_rd, d_wr;
        logic [135:0] exp_all;
        owner = 0; i_pend = 1'b0; d_pend = 1'b0; i_done = 1'b0; d_done = 1'b0;
        d_rd = 1'b0; d_wr = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (i_done) i_pend = 1'b0;
            if (d_done) d_pend = 1'b0;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1; iaddr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; daddr = $urandom; dwdata = $urandom;
                dfunct3 = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0, 1:    begin d_rd = 1'b1; d_wr = 1'b0; end
                    2:       begin d_rd = 1'b0; d_wr = 1'b1; end
                    default: begin d_rd = 1'b1; d_wr = 1'b1; end
                endcase
            end
            ireq   = i_pend;
            dread  = d_pend & d_rd;
            dwrite = d_pend & d_wr;
            mem_ready = ($urandom_range(0, 4) < 2);
            mem_rdata = $urandom;
            #1;
            exp_all = '0;
            if (owner == 1) begin
                exp_all = {(mem_ready ? mem_rdata : 32'h0), mem_ready, 32'h0, 1'b0,
                           iaddr, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1};
            end else if (owner == 2) begin
                exp_all = {32'h0, 1'b0, (mem_ready ? mem_rdata : 32'h0), mem_ready,
                           daddr, dwdata, d_rd & ~d_wr, d_wr, dfunct3, 1'b1};
            end
            total++;
            if (all_nc !== exp_all) begin
                bad++; $display("FAIL rand_out c=%0d owner=%0d: got %h want %h", c, owner, all_nc, exp_all);
            end
            total++;
            if ({conflict_cnt, s_conflict_cnt} !== {exp_cnt[15:0], sat4(exp_cnt)}) begin
                bad++; $display("FAIL rand_cnt c=%0d: got %0d/%h want %0d/%h",
                                c, conflict_cnt, s_conflict_cnt, exp_cnt, sat4(exp_cnt));
            end
            i_done = (owner == 1) && mem_ready;
            d_done = (owner == 2) && mem_ready;
            if (owner == 0) begin
                if (i_pend && d_pend) begin
                    exp_cnt++;
                    owner = winner(exp_last);
                end else if (d_pend) begin
                    owner = 2;
                end else if (i_pend) begin
                    owner = 1;
                end
            end else if (mem_ready) begin
                exp_last = owner;
                owner = 0;
            end
        end
        tick(); clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store();
        test_conflict();
        test_withdraw();
        test_reset_mid();
        test_saturation();
        test_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
